// File: rtl/pri_arb_4_ctrl.sv
// Four-requester arbiter for one shared resource: fixed-priority or round-robin selection,
// registered one-hot grant held until the owner releases or its hold limit expires.
module pri_arb_4_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               HAS_LIMIT = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        gnt_id_q, gnt_id_d;
  logic              busy_q, busy_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        rr_last_q, rr_last_d;

  logic [3:0] cand;
  logic [1:0] win;
  logic       rel;

  function automatic logic [1:0] fixed_pick(input logic [3:0] r);
    logic [1:0] pick;
    if (r[3])      pick = 2'd3;
    else if (r[2]) pick = 2'd2;
    else if (r[1]) pick = 2'd1;
    else           pick = 2'd0;
    return pick;
  endfunction

  // Searches last+1, last+2, last+3, last (mod 4); the first requester found wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    rr_last_d  = rr_last_q;

    // In GRANT the current owner is excluded from the candidate set.
    cand = (state_q == IDLE) ? req : (req & ~gnt_q);
    win  = mode ? rr_pick(cand, rr_last_q) : fixed_pick(cand);
    rel  = ~req[gnt_id_q] | (HAS_LIMIT & (hold_cnt_q == HOLD_LAST));

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << win;
          gnt_id_d   = win;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          rr_last_d  = win;
        end
      end
      GRANT: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        if (rel) begin
          if (|cand) begin
            gnt_d      = 4'b0001 << win;
            gnt_id_d   = win;
            hold_cnt_d = '0;
            rr_last_d  = win;
          end else if (req[gnt_id_q]) begin
            // Hold limit expired with nobody else waiting: re-grant the same owner.
            hold_cnt_d = '0;
            rr_last_d  = gnt_id_q;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
      rr_last_q  <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
